// File: rtl/fft_pkg.sv
// Shared types for the FFT front end: complex sample layout and loader FSM states.
package fft_pkg;

  localparam int CPLX_FRAC_BITS = 15;
  localparam int RE = 0;
  localparam int IM = 1;

  typedef logic [1:0][CPLX_FRAC_BITS:0] cplx_t;

  typedef enum logic {
    ST_FILL = 1'b0,
    ST_WAIT = 1'b1
  } loader_state_t;

endpackage

// File: rtl/fft_frame_loader.sv
// Collects a stream of complex samples into a parallel POINT_FFT-wide frame,
// double-buffered so a new frame can fill while the previous one waits downstream.
module fft_frame_loader
  import fft_pkg::*;
#(
  parameter int POINT_FFT_POW2 = 4,
  parameter int FRAC_BITS      = 15
) (
  input  logic                                      clk_i,
  input  logic                                      rst_i,
  input  logic                                      s_valid_i,
  output logic                                      s_ready_o,
  input  logic [1:0][FRAC_BITS:0]                   s_data_i,
  input  logic                                      s_last_i,
  output logic [(1<<POINT_FFT_POW2)-1:0][1:0][FRAC_BITS:0] frame_o,
  output logic                                      frame_valid_o,
  input  logic                                      frame_ready_i,
  output logic                                      len_err_o,
  output logic [15:0]                               frame_cnt_o
);

  localparam int POINT_FFT = 1 << POINT_FFT_POW2;
  localparam logic [POINT_FFT_POW2-1:0] IDX_LAST = POINT_FFT_POW2'(POINT_FFT - 1);
  localparam logic [POINT_FFT_POW2-1:0] IDX_ONE  = POINT_FFT_POW2'(1);

  loader_state_t                              r_state;
  logic [POINT_FFT_POW2-1:0]                  r_wr_idx;
  logic [POINT_FFT-1:0][1:0][FRAC_BITS:0]     r_buf;
  logic [POINT_FFT-1:0][1:0][FRAC_BITS:0]     r_frame;
  logic                                       r_frame_valid;
  logic                                       r_len_err;
  logic [15:0]                                r_frame_cnt;

  loader_state_t                              w_state_next;
  logic [POINT_FFT_POW2-1:0]                  w_wr_idx_next;
  logic                                       w_valid_next;
  logic                                       w_len_err_next;
  logic                                       w_load_new;
  logic                                       w_load_buf;
  logic                                       w_s_xfer;
  logic                                       w_f_xfer;
  logic                                       w_out_free;
  logic [POINT_FFT-1:0][1:0][FRAC_BITS:0]     w_full_frame;

  assign s_ready_o     = !rst_i && (r_state == ST_FILL);
  assign frame_o       = r_frame;
  assign frame_valid_o = r_frame_valid;
  assign len_err_o     = r_len_err;
  assign frame_cnt_o   = r_frame_cnt;

  assign w_s_xfer   = s_valid_i && s_ready_o;
  assign w_f_xfer   = r_frame_valid && frame_ready_i;
  assign w_out_free = !r_frame_valid || w_f_xfer;

  // The closing sample bypasses the buffer so the frame is visible one cycle after it.
  always_comb begin
    w_full_frame                = r_buf;
    w_full_frame[POINT_FFT-1]   = s_data_i;
  end

  always_comb begin
    w_state_next   = r_state;
    w_wr_idx_next  = r_wr_idx;
    w_valid_next   = r_frame_valid;
    w_len_err_next = 1'b0;
    w_load_new     = 1'b0;
    w_load_buf     = 1'b0;
    if (w_f_xfer) begin
      w_valid_next = 1'b0;
    end
    case (r_state)
      ST_FILL: begin
        if (w_s_xfer) begin
          if (r_wr_idx == IDX_LAST) begin
            w_wr_idx_next = '0;
            if (w_out_free) begin
              w_load_new   = 1'b1;
              w_valid_next = 1'b1;
            end else begin
              w_state_next = ST_WAIT;
            end
          end else if (s_last_i) begin
            w_wr_idx_next  = '0;
            w_len_err_next = 1'b1;
          end else begin
            w_wr_idx_next = r_wr_idx + IDX_ONE;
          end
        end
      end
      ST_WAIT: begin
        if (w_f_xfer) begin
          w_load_buf   = 1'b1;
          w_valid_next = 1'b1;
          w_state_next = ST_FILL;
        end
      end
      default: w_state_next = ST_FILL;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state       <= ST_FILL;
      r_wr_idx      <= '0;
      r_frame_valid <= 1'b0;
      r_len_err     <= 1'b0;
      r_frame_cnt   <= '0;
      r_frame       <= '0;
      r_buf         <= '0;
    end else begin
      r_state       <= w_state_next;
      r_wr_idx      <= w_wr_idx_next;
      r_frame_valid <= w_valid_next;
      r_len_err     <= w_len_err_next;
      if (w_s_xfer) begin
        r_buf[r_wr_idx] <= s_data_i;
      end
      if (w_load_new) begin
        r_frame <= w_full_frame;
      end else if (w_load_buf) begin
        r_frame <= r_buf;
      end
      if (w_f_xfer) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Randomized bench for fft_frame_loader against a queue-based frame model.
module tb_fft_frame_loader;
  import fft_pkg::*;

  localparam int POW2 = 4;
  localparam int FB   = 15;
  localparam int N    = 1 << POW2;
  localparam int FW   = N * 2 * (FB + 1);

  typedef logic [1:0][FB:0]        cplx_l;
  typedef logic [N-1:0][1:0][FB:0] frame_l;

  logic   clk_i;
  logic   rst_i;
  logic   s_valid_i;
  logic   s_ready_o;
  cplx_l  s_data_i;
  logic   s_last_i;
  frame_l frame_o;
  logic   frame_valid_o;
  logic   frame_ready_i;
  logic   len_err_o;
  logic [15:0] frame_cnt_o;

  fft_frame_loader #(.POINT_FFT_POW2(POW2), .FRAC_BITS(FB)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .s_valid_i    (s_valid_i),
    .s_ready_o    (s_ready_o),
    .s_data_i     (s_data_i),
    .s_last_i     (s_last_i),
    .frame_o      (frame_o),
    .frame_valid_o(frame_valid_o),
    .frame_ready_i(frame_ready_i),
    .len_err_o    (len_err_o),
    .frame_cnt_o  (frame_cnt_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Model: samples of the frame being gathered, and completed frames not yet consumed.
  cplx_l       cur_q[$];
  frame_l      exp_q[$];
  int unsigned delivered;
  bit          exp_len_err;
  bit          hold_prev;
  frame_l      hold_frame;
  int          checks;
  int          failures;

  task automatic check_eq(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick(output bit acc);
    bit     drop;
    frame_l f;
    @(negedge clk_i);
    acc  = 1'b0;
    drop = 1'b0;
    if (rst_i) begin
      check_eq("ready_in_reset", FW'(s_ready_o), FW'(0));
      cur_q.delete();
      exp_q.delete();
      delivered   = 0;
      exp_len_err = 1'b0;
      hold_prev   = 1'b0;
    end else begin
      check_eq("s_ready", FW'(s_ready_o), FW'(exp_q.size() < 2));
      check_eq("frame_valid", FW'(frame_valid_o), FW'(exp_q.size() > 0));
      check_eq("len_err", FW'(len_err_o), FW'(exp_len_err));
      check_eq("frame_cnt", FW'(frame_cnt_o), FW'(delivered[15:0]));
      if (hold_prev) check_eq("hold_stable", frame_o, hold_frame);
      hold_prev  = frame_valid_o && !frame_ready_i;
      hold_frame = frame_o;
      if (frame_valid_o && frame_ready_i) begin
        if (exp_q.size() > 0) begin
          check_eq("frame_data", frame_o, exp_q[0]);
          void'(exp_q.pop_front());
        end
        delivered++;
      end
      if (s_valid_i && s_ready_o) begin
        acc = 1'b1;
        cur_q.push_back(s_data_i);
        if (cur_q.size() == N) begin
          for (int i = 0; i < N; i++) f[i] = cur_q[i];
          exp_q.push_back(f);
          cur_q.delete();
        end else if (s_last_i) begin
          cur_q.delete();
          drop = 1'b1;
        end
      end
      exp_len_err = drop;
    end
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input cplx_l d, input bit last);
    bit acc;
    int budget;
    s_valid_i = 1'b1;
    s_data_i  = d;
    s_last_i  = last;
    budget    = 0;
    acc       = 1'b0;
    while (!acc && budget < 200) begin
      tick(acc);
      budget++;
    end
    if (!acc) check_eq("send_timeout", FW'(acc), FW'(1));
    s_valid_i = 1'b0;
    s_last_i  = 1'b0;
  endtask

  task automatic idle(input int n);
    bit acc;
    s_valid_i = 1'b0;
    for (int i = 0; i < n; i++) tick(acc);
  endtask

  task automatic do_reset();
    bit acc;
    rst_i = 1'b1;
    tick(acc);
    tick(acc);
    rst_i = 1'b0;
    check_eq("reset_frame", frame_o, FW'(0));
  endtask

  function automatic cplx_l rnd_sample();
    cplx_l d;
    d[RE] = 16'($urandom);
    d[IM] = 16'($urandom);
    return d;
  endfunction

  initial begin
    cplx_l d;
    bit    acc;
    checks        = 0;
    failures      = 0;
    delivered     = 0;
    exp_len_err   = 1'b0;
    hold_prev     = 1'b0;
    rst_i         = 1'b1;
    s_valid_i     = 1'b0;
    s_data_i      = '0;
    s_last_i      = 1'b0;
    frame_ready_i = 1'b1;

    do_reset();
    idle(2);

    // Constant 0.5 frame
    for (int n = 0; n < N; n++) begin
      d[RE] = 16'h4000;
      d[IM] = 16'h0000;
      send(d, n == N - 1);
    end
    idle(3);
    check_eq("cnt_after_first", FW'(frame_cnt_o), FW'(1));

    // Ramp: Re=n, Im=-n
    for (int n = 0; n < N; n++) begin
      d[RE] = 16'(n);
      d[IM] = 16'(-n);
      send(d, 1'b0);
    end
    idle(3);

    // Downstream stalled across two frames
    frame_ready_i = 1'b0;
    for (int n = 0; n < 2 * N; n++) send(rnd_sample(), n % N == N - 1);
    s_valid_i = 1'b1;
    s_data_i  = rnd_sample();
    for (int i = 0; i < 4; i++) tick(acc);
    check_eq("stalled_not_ready", FW'(s_ready_o), FW'(0));
    s_valid_i     = 1'b0;
    frame_ready_i = 1'b1;
    idle(4);

    // Short frame dropped, then a clean one
    for (int n = 0; n < 5; n++) send(rnd_sample(), n == 4);
    for (int n = 0; n < N; n++) send(rnd_sample(), n == N - 1);
    idle(3);

    // Four back-to-back frames
    for (int n = 0; n < 4 * N; n++) send(rnd_sample(), 1'b0);
    idle(3);
    check_eq("cnt_after_burst", FW'(frame_cnt_o), FW'(9));

    // Reset mid-frame
    for (int n = 0; n < 9; n++) send(rnd_sample(), 1'b0);
    do_reset();
    for (int n = 0; n < N; n++) send(rnd_sample(), 1'b0);
    idle(3);
    check_eq("cnt_after_reset", FW'(frame_cnt_o), FW'(1));

    // Random traffic
    for (int i = 0; i < 1500; i++) begin
      frame_ready_i = ($urandom_range(0, 3) != 0);
      s_valid_i     = ($urandom_range(0, 3) != 0);
      s_data_i      = rnd_sample();
      s_last_i      = ($urandom_range(0, 11) == 0);
      tick(acc);
    end
    s_last_i      = 1'b0;
    frame_ready_i = 1'b1;
    idle(10);
    check_eq("drained_valid", FW'(frame_valid_o), FW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fft_frame_loader.md
FFT_FRAME_LOADER -- requirements
Module: fft_frame_loader

Interface
REQ-001 The module SHALL have parameter POINT_FFT_POW2, default 4, which sets the frame length as log2 of POINT_FFT.
REQ-002 The module SHALL have parameter FRAC_BITS, default 15, which sets each component as signed Q1.FRAC_BITS of width FRAC_BITS+1.
REQ-003 The module SHALL derive localparam POINT_FFT = 1 << POINT_FFT_POW2.
REQ-004 The module SHALL have port clk_i, input, 1 bit: the single clock; all logic rises on it.
REQ-005 The module SHALL have port rst_i, input, 1 bit: reset, synchronous and active-high.
REQ-006 The module SHALL have port s_valid_i, input, 1 bit: the streaming input sample is valid.
REQ-007 The module SHALL have port s_ready_o, output, 1 bit: the loader accepts a sample.
REQ-008 The module SHALL have port s_data_i, input, [1:0][FRAC_BITS:0]: index 0 = Re, index 1 = Im.
REQ-009 The module SHALL have port s_last_i, input, 1 bit: marks the last sample of a frame.
REQ-010 The module SHALL have port frame_o, output, [POINT_FFT-1:0][1:0][FRAC_BITS:0]: the parallel frame, wired directly to data_i of top_fft.
REQ-011 The module SHALL have port frame_valid_o, output, 1 bit: frame_o holds a complete frame.
REQ-012 The module SHALL have port frame_ready_i, input, 1 bit: the downstream consumer takes the frame.
REQ-013 The module SHALL have port len_err_o, output, 1 bit: one-cycle pulse when a short frame is dropped.
REQ-014 The module SHALL have port frame_cnt_o, output, 16 bits: count of frames delivered, wrapping.

Function
REQ-015 A sample transfer SHALL occur when s_valid_i && s_ready_o; a frame transfer SHALL occur when frame_valid_o && frame_ready_i.
REQ-016 The write index wr_idx SHALL be POINT_FFT_POW2 bits; each sample transfer SHALL write fill buffer slot wr_idx and increment wr_idx, wrapping N-1 -> 0.
REQ-017 The FSM SHALL have two states, FILL and WAIT; s_ready_o SHALL be 1 in FILL and 0 in WAIT.
REQ-018 When the sample at wr_idx==N-1 is accepted in FILL and the output is free (frame_valid_o==0 or a frame transfer occurs in the same cycle), the next cycle SHALL have frame_o = {that sample, buffer[N-2:0]}, frame_valid_o=1, state FILL, wr_idx=0.
REQ-019 When the sample at wr_idx==N-1 is accepted in FILL and the output is busy, that sample SHALL be stored in the fill buffer and the state SHALL go to WAIT.
REQ-020 In WAIT, a frame transfer SHALL cause frame_o to load the fill buffer on the next cycle, with frame_valid_o remaining 1, the state returning to FILL and wr_idx=0.
REQ-021 On a frame transfer with no replacement frame ready, frame_valid_o SHALL be 0 on the next cycle.
REQ-022 frame_o SHALL be stable while frame_valid_o && !frame_ready_i.
REQ-023 frame_cnt_o SHALL increment by 1 on each frame transfer, wrapping 0xFFFF -> 0.
REQ-024 s_last_i accepted with wr_idx < N-1 SHALL drop the partial frame: wr_idx=0, a len_err_o pulse the next cycle, and the output register untouched.
REQ-025 s_last_i=0 on sample N-1 SHALL be ignored, and the frame SHALL complete normally.
REQ-026 Latency from the Nth sample accept to frame_valid_o (output free) SHALL be 1 cycle.
REQ-027 Sustained throughput SHALL be 1 sample/cycle when frame_ready_i is held at 1.
REQ-028 Samples SHALL be stored bit-exact, with no scaling or rounding.

Reset
REQ-029 While rst_i=1 at a clock edge: state=FILL, wr_idx=0, frame_valid_o=0, len_err_o=0, frame_cnt_o=0, frame_o=0, fill buffer=0.
REQ-030 s_ready_o SHALL be 0 while rst_i=1 and 1 in the first cycle after rst_i is released.
REQ-031 Reset mid-frame or in WAIT SHALL discard all partial and pending data, with no frame emitted afterwards.

Structure
REQ-032 A shared package fft_pkg SHALL hold the cplx_t typedef ([1:0][FRAC_BITS:0]), RE=0 and IM=1 index constants, and the loader_state_t enum.
REQ-033 The design SHALL be a single module with no sub-modules; the fill buffer and the output register are flop arrays.

Verification
REQ-034 Reset then 16 samples of Re=16'h4000, Im=0 with frame_ready_i=1 -> frame_valid_o one cycle after the 16th accept, all frame_o[n][0]=16'h4000, frame_cnt_o=1.
REQ-035 Ramp Re=n, Im=-n for n=0..15 -> frame_o[n]={-n,n}, proving index order and Im sign.
REQ-036 frame_ready_i=0 while 32 samples are offered -> frame 1 held stable, s_ready_o=0 after 32 accepts; raising frame_ready_i -> frame 2 appears next cycle, s_ready_o=1.
REQ-037 s_last_i on the 5th sample -> len_err_o pulse, no frame; the next 16 samples form a clean frame.
REQ-038 Continuous 64 samples with ready=1 -> 4 frames, no stall, frame_cnt_o=4.
REQ-039 rst_i asserted after 9 samples, then 16 samples -> exactly one frame containing only the post-reset samples.
